// File: rtl/neuron_sequencer_pkg.sv
// Shared types and saturating arithmetic for the time-multiplexed neuron sequencer.
package neuron_pkg;

    localparam int POT_W = 8;

    typedef logic [POT_W-1:0] pot_t;

    typedef enum logic [1:0] {
        ST_INTEGRATE  = 2'd0,
        ST_SWEEP      = 2'd1,
        ST_SPIKE_WAIT = 2'd2,
        ST_DONE       = 2'd3
    } state_t;

    // Unsigned add clamped at all-ones
    function automatic pot_t sat_add(input pot_t a, input pot_t b);
        logic [POT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[POT_W] ? {POT_W{1'b1}} : s[POT_W-1:0];
    endfunction

    // Unsigned subtract clamped at zero
    function automatic pot_t sat_sub(input pot_t a, input pot_t b);
        return (a > b) ? pot_t'(a - b) : '0;
    endfunction

endpackage

// File: rtl/neuron_sequencer_if.sv
// Spike-event input and spike output handshakes of the neuron sequencer.
interface neuron_sequencer_if #(
    parameter int IDW = 4
);
    logic           event_valid_i;
    logic           event_ready_o;
    logic [IDW-1:0] event_neuron_i;
    logic [1:0]     event_weight_sel_i;
    logic           spike_valid_o;
    logic           spike_ready_i;
    logic [IDW-1:0] spike_id_o;

    // Sequencer side
    modport slave (
        input  event_valid_i, event_neuron_i, event_weight_sel_i, spike_ready_i,
        output event_ready_o, spike_valid_o, spike_id_o
    );

    // Event source / spike sink side
    modport master (
        output event_valid_i, event_neuron_i, event_weight_sel_i, spike_ready_i,
        input  event_ready_o, spike_valid_o, spike_id_o
    );
endinterface

// File: rtl/neuron_update.sv
// Leak and threshold evaluation for one neuron; purely combinational.
module neuron_update
    import neuron_pkg::*;
(
    input  pot_t potential,
    input  pot_t leak,
    input  pot_t pos_threshold,
    input  pot_t neg_threshold,
    input  pot_t pos_reset,
    input  pot_t neg_reset,
    output pot_t next_potential,
    output logic fire
);
    pot_t leaked;

    // Leak, then fire on the positive threshold or clamp on the negative one
    always_comb begin
        leaked         = sat_sub(potential, leak);
        fire           = 1'b0;
        next_potential = leaked;
        if (leaked >= pos_threshold) begin
            fire           = 1'b1;
            next_potential = pos_reset;
        end else if (leaked <= neg_threshold) begin
            next_potential = neg_reset;
        end
    end
endmodule

// File: rtl/neuron_sequencer.sv
// Time-multiplexed integrate-and-fire sequencer: integrates weighted spike
// events, then on each tick sweeps every neuron once for leak and fire.
module neuron_sequencer
    import neuron_pkg::*;
#(
    parameter int NUM_NEURONS = 16,
    parameter int IDW         = $clog2(NUM_NEURONS)
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           tick_i,
    neuron_sequencer_if.slave bus,
    input  logic [7:0]     weight_type1_i,
    input  logic [7:0]     weight_type2_i,
    input  logic [7:0]     weight_type3_i,
    input  logic [7:0]     weight_type4_i,
    input  logic [7:0]     leak_value_i,
    input  logic [7:0]     pos_threshold_i,
    input  logic [7:0]     neg_threshold_i,
    input  logic [7:0]     pos_reset_i,
    input  logic [7:0]     neg_reset_i,
    output logic           done_o,
    output logic           busy_o,
    output logic           overrun_o,
    input  logic [IDW-1:0] dbg_addr_i,
    output logic [7:0]     dbg_potential_o
);
    pot_t           pot [NUM_NEURONS];
    state_t         state_q, state_d;
    logic [IDW-1:0] idx_q, idx_d;
    logic           overrun_q;

    pot_t           weight;
    pot_t           upd_pot;
    pot_t           sweep_wdata;
    logic           fire;
    logic           evt_we;
    logic           sweep_we;
    logic           last;

    assign last            = (idx_q == IDW'(NUM_NEURONS - 1));
    assign bus.spike_id_o  = idx_q;
    assign overrun_o       = overrun_q;
    assign dbg_potential_o = pot[dbg_addr_i];

    // Synaptic weight selected by the incoming event
    always_comb begin
        weight = weight_type1_i;
        case (bus.event_weight_sel_i)
            2'd0: weight = weight_type1_i;
            2'd1: weight = weight_type2_i;
            2'd2: weight = weight_type3_i;
            2'd3: weight = weight_type4_i;
            default: weight = weight_type1_i;
        endcase
    end

    neuron_update u_update (
        .potential      (pot[idx_q]),
        .leak           (leak_value_i),
        .pos_threshold  (pos_threshold_i),
        .neg_threshold  (neg_threshold_i),
        .pos_reset      (pos_reset_i),
        .neg_reset      (neg_reset_i),
        .next_potential (upd_pot),
        .fire           (fire)
    );

    // State, sweep index and sticky overrun registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_INTEGRATE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (tick_i && state_q != ST_INTEGRATE)
                overrun_q <= 1'b1;
        end
    end

    // Next state, handshakes and potential write enables
    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        bus.event_ready_o = 1'b0;
        bus.spike_valid_o = 1'b0;
        done_o            = 1'b0;
        busy_o            = 1'b1;
        evt_we            = 1'b0;
        sweep_we          = 1'b0;
        sweep_wdata       = upd_pot;
        case (state_q)
            ST_INTEGRATE: begin
                busy_o            = 1'b0;
                bus.event_ready_o = 1'b1;
                evt_we            = bus.event_valid_i;
                if (tick_i)
                    state_d = ST_SWEEP;
            end
            ST_SWEEP: begin
                // A spike accepted in the same cycle costs no stall
                bus.spike_valid_o = fire;
                sweep_we          = !fire || bus.spike_ready_i;
                if (fire && !bus.spike_ready_i)
                    state_d = ST_SPIKE_WAIT;
            end
            ST_SPIKE_WAIT: begin
                bus.spike_valid_o = 1'b1;
                sweep_wdata       = pos_reset_i;
                sweep_we          = bus.spike_ready_i;
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_INTEGRATE;
            end
            default: state_d = ST_INTEGRATE;
        endcase
        // Finishing a neuron moves to the next index or ends the sweep
        if (sweep_we) begin
            if (last) begin
                idx_d   = '0;
                state_d = ST_DONE;
            end else begin
                idx_d   = idx_q + IDW'(1);
                state_d = ST_SWEEP;
            end
        end
    end

    // Potential store: event integration or sweep write-back
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_NEURONS; i++)
                pot[i] <= '0;
        end else if (evt_we) begin
            pot[bus.event_neuron_i] <= sat_add(pot[bus.event_neuron_i], weight);
        end else if (sweep_we) begin
            pot[idx_q] <= sweep_wdata;
        end
    end
endmodule
